// File: rtl/ofm_addr_controller_pkg.sv
// Shared types and helpers for the OFM write-address path and its IFM read-side twin.
package ofm_addr_controller_pkg;

    localparam int unsigned DEFAULT_SYSTOLIC_SIZE = 16;
    localparam int unsigned DEFAULT_OFM_RAM_SIZE  = 2076672;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        NEXT_TILE = 2'd2
    } state_e;

    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

    function automatic int unsigned addr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/ofm_tile_counter.sv
// Tile walker: row, then column strip, then filter group; keeps a running tile base address.
module ofm_tile_counter
    import ofm_addr_controller_pkg::*;
#(
    parameter int unsigned SYSTOLIC_SIZE = DEFAULT_SYSTOLIC_SIZE,
    parameter int unsigned ADDR_W        = 21
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [8:0]        ofm_size,
    input  logic [10:0]       num_filter,
    input  logic [ADDR_W-1:0] plane,
    input  logic              advance,
    output logic [4:0]        lanes_c,
    output logic [4:0]        seg_c,
    output logic [ADDR_W-1:0] tile_base,
    output logic              last_tile_c
);

    localparam logic [8:0]  S_COL = 9'(SYSTOLIC_SIZE);
    localparam logic [10:0] S_FG  = 11'(SYSTOLIC_SIZE);

    logic [8:0]        row;
    logic [8:0]        col_base;
    logic [10:0]       fg_base;
    logic [ADDR_W-1:0] fg_off;

    logic [10:0]       f_left;
    logic [8:0]        px_left;
    logic [8:0]        col_next;
    logic [ADDR_W-1:0] fg_step;
    logic              row_last;
    logic              col_last;
    logic              fg_last;

    always_comb begin
        f_left      = num_filter - fg_base;
        px_left     = ofm_size - col_base;
        lanes_c     = 5'(min_u(32'(f_left), SYSTOLIC_SIZE));
        seg_c       = 5'(min_u(32'(px_left), SYSTOLIC_SIZE));
        col_next    = col_base + S_COL;
        fg_step     = plane * ADDR_W'(SYSTOLIC_SIZE);
        row_last    = (row == ofm_size - 9'd1);
        col_last    = (col_base + 9'(seg_c) == ofm_size);
        fg_last     = (fg_base + 11'(lanes_c) == num_filter);
        last_tile_c = row_last && col_last && fg_last;
    end

    // fg_off tracks fg_base*plane so tile_base never needs a multiply per step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row       <= '0;
            col_base  <= '0;
            fg_base   <= '0;
            fg_off    <= '0;
            tile_base <= '0;
        end else if (advance) begin
            if (!row_last) begin
                row       <= row + 9'd1;
                tile_base <= tile_base + ADDR_W'(ofm_size);
            end else if (!col_last) begin
                row       <= '0;
                col_base  <= col_next;
                tile_base <= fg_off + ADDR_W'(col_next);
            end else if (!fg_last) begin
                row       <= '0;
                col_base  <= '0;
                fg_base   <= fg_base + S_FG;
                fg_off    <= fg_off + fg_step;
                tile_base <= fg_off + fg_step;
            end else begin
                row       <= '0;
                col_base  <= '0;
                fg_base   <= '0;
                fg_off    <= '0;
                tile_base <= '0;
            end
        end
    end

endmodule

// File: rtl/ofm_addr_controller.sv
// OFM write-address generator: drains one filter row per write for each output tile.
module ofm_addr_controller
    import ofm_addr_controller_pkg::*;
#(
    parameter int unsigned SYSTOLIC_SIZE = DEFAULT_SYSTOLIC_SIZE,
    parameter int unsigned OFM_RAM_SIZE  = DEFAULT_OFM_RAM_SIZE,
    localparam int unsigned ADDR_W       = addr_width(OFM_RAM_SIZE),
    localparam int unsigned SEL_W        = $clog2(SYSTOLIC_SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              wr_ready,
    input  logic [8:0]        ofm_size,
    input  logic [10:0]       num_filter,
    output logic [ADDR_W-1:0] ofm_addr,
    output logic              write_en,
    output logic [4:0]        write_ofm_size,
    output logic [SEL_W-1:0]  filter_sel,
    output logic              busy,
    output logic              tile_done,
    output logic              layer_done
);

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] addr_d;
    logic [SEL_W-1:0]  sel_d;
    logic [4:0]        size_d;

    logic [ADDR_W-1:0] plane;
    logic [ADDR_W-1:0] tile_base;
    logic [4:0]        lanes_c;
    logic [4:0]        seg_c;
    logic              last_tile_c;
    logic              advance_c;

    assign plane     = ADDR_W'(ofm_size) * ADDR_W'(ofm_size);
    assign advance_c = (state_q == NEXT_TILE);

    ofm_tile_counter #(
        .SYSTOLIC_SIZE (SYSTOLIC_SIZE),
        .ADDR_W        (ADDR_W)
    ) u_tile_counter (
        .clk         (clk),
        .rst         (rst),
        .ofm_size    (ofm_size),
        .num_filter  (num_filter),
        .plane       (plane),
        .advance     (advance_c),
        .lanes_c     (lanes_c),
        .seg_c       (seg_c),
        .tile_base   (tile_base),
        .last_tile_c (last_tile_c)
    );

    // Next state and next write descriptor; a stall simply leaves everything held
    always_comb begin
        state_d = state_q;
        addr_d  = ofm_addr;
        sel_d   = filter_sel;
        size_d  = write_ofm_size;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WRITE;
                    addr_d  = tile_base;
                    sel_d   = '0;
                    size_d  = seg_c;
                end
            end
            WRITE: begin
                if (wr_ready) begin
                    if (5'(filter_sel) == lanes_c - 5'd1) begin
                        state_d = NEXT_TILE;
                    end else begin
                        sel_d  = filter_sel + SEL_W'(1);
                        addr_d = ofm_addr + plane;
                    end
                end
            end
            NEXT_TILE: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            ofm_addr       <= '0;
            filter_sel     <= '0;
            write_ofm_size <= '0;
            write_en       <= 1'b0;
            busy           <= 1'b0;
            tile_done      <= 1'b0;
            layer_done     <= 1'b0;
        end else begin
            state_q        <= state_d;
            ofm_addr       <= addr_d;
            filter_sel     <= sel_d;
            write_ofm_size <= size_d;
            write_en       <= (state_d == WRITE);
            busy           <= (state_d != IDLE);
            tile_done      <= (state_d == NEXT_TILE);
            layer_done     <= (state_d == NEXT_TILE) && last_tile_c;
        end
    end

endmodule

// File: tb/tb_ofm_addr_controller.sv
// Directed bench for ofm_addr_controller: raster, strips, filter groups, stall, dropped start, reset.
module tb_ofm_addr_controller;

    logic        clk;
    logic        rst;
    logic        start;
    logic        wr_ready;
    logic [8:0]  ofm_size;
    logic [10:0] num_filter;
    logic [20:0] ofm_addr;
    logic        write_en;
    logic [4:0]  write_ofm_size;
    logic [3:0]  filter_sel;
    logic        busy;
    logic        tile_done;
    logic        layer_done;

    int n_checks;
    int n_fail;

    ofm_addr_controller dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .wr_ready       (wr_ready),
        .ofm_size       (ofm_size),
        .num_filter     (num_filter),
        .ofm_addr       (ofm_addr),
        .write_en       (write_en),
        .write_ofm_size (write_ofm_size),
        .filter_sel     (filter_sel),
        .busy           (busy),
        .tile_done      (tile_done),
        .layer_done     (layer_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One tile: optional stall on write stall_at, optional stray start during write drop_at
    task automatic run_tile(input int base, input int plane, input int lanes, input int seg,
                            input bit last, input int stall_at, input int stall_len,
                            input int drop_at);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int f = 0; f < lanes; f++) begin
            if (f == stall_at) begin
                wr_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    check($sformatf("stall_we b%0d f%0d s%0d", base, f, s), 32'(write_en), 32'd1);
                    check($sformatf("stall_addr b%0d f%0d s%0d", base, f, s), 32'(ofm_addr), 32'(base + f * plane));
                    check($sformatf("stall_sel b%0d f%0d s%0d", base, f, s), 32'(filter_sel), 32'(f));
                    check($sformatf("stall_size b%0d f%0d s%0d", base, f, s), 32'(write_ofm_size), 32'(seg));
                    @(negedge clk);
                end
                wr_ready = 1'b1;
            end
            if (f == drop_at) start = 1'b1;
            check($sformatf("we b%0d f%0d", base, f), 32'(write_en), 32'd1);
            check($sformatf("addr b%0d f%0d", base, f), 32'(ofm_addr), 32'(base + f * plane));
            check($sformatf("sel b%0d f%0d", base, f), 32'(filter_sel), 32'(f));
            check($sformatf("size b%0d f%0d", base, f), 32'(write_ofm_size), 32'(seg));
            @(negedge clk);
            start = 1'b0;
        end
        check($sformatf("tile_done b%0d", base), 32'(tile_done), 32'd1);
        check($sformatf("layer_done b%0d", base), 32'(layer_done), 32'(last));
        check($sformatf("we_off b%0d", base), 32'(write_en), 32'd0);
        @(negedge clk);
        check($sformatf("idle_busy b%0d", base), 32'(busy), 32'd0);
        check($sformatf("idle_done b%0d", base), 32'(tile_done), 32'd0);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        start      = 1'b0;
        wr_ready   = 1'b1;
        ofm_size   = 9'd4;
        num_filter = 11'd2;
        repeat (2) @(negedge clk);
        check("rst_addr", 32'(ofm_addr), 32'd0);
        check("rst_we", 32'(write_en), 32'd0);
        check("rst_sel", 32'(filter_sel), 32'd0);
        check("rst_size", 32'(write_ofm_size), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tile_done", 32'(tile_done), 32'd0);
        check("rst_layer_done", 32'(layer_done), 32'd0);
        rst = 1'b0;

        // Basic raster: plane 16, two lanes, four rows
        for (int t = 0; t < 4; t++)
            run_tile(t * 4, 16, 2, 4, (t == 3), -1, 0, -1);

        // Filter groups: 16 lanes then 4 lanes at base 64
        ofm_size   = 9'd2;
        num_filter = 11'd20;
        run_tile(0, 4, 16, 2, 1'b0, -1, 0, -1);
        run_tile(2, 4, 16, 2, 1'b0, -1, 0, -1);
        run_tile(64, 4, 4, 2, 1'b0, -1, 0, -1);
        run_tile(66, 4, 4, 2, 1'b1, -1, 0, -1);

        // Column strips: 16-wide strip then 4-wide remainder
        ofm_size   = 9'd20;
        num_filter = 11'd1;
        for (int t = 0; t < 40; t++) begin
            if (t < 20) run_tile(t * 20, 400, 1, 16, 1'b0, -1, 0, -1);
            else        run_tile(16 + (t - 20) * 20, 400, 1, 4, (t == 39), -1, 0, -1);
        end

        // Stall three cycles on the second write, then a stray start mid-tile
        ofm_size   = 9'd4;
        num_filter = 11'd3;
        run_tile(0, 16, 3, 4, 1'b0, 1, 3, -1);
        run_tile(4, 16, 3, 4, 1'b0, -1, 0, 1);
        @(negedge clk);
        check("drop_busy", 32'(busy), 32'd0);
        check("drop_we", 32'(write_en), 32'd0);
        check("drop_tile_done", 32'(tile_done), 32'd0);

        // Reset during the third write of the row-2 tile
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_addr", 32'(ofm_addr), 32'd40);
        check("pre_rst_sel", 32'(filter_sel), 32'd2);
        #2 rst = 1'b1;
        #1;
        check("async_rst_we", 32'(write_en), 32'd0);
        check("async_rst_addr", 32'(ofm_addr), 32'd0);
        check("async_rst_sel", 32'(filter_sel), 32'd0);
        check("async_rst_size", 32'(write_ofm_size), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_tile(0, 16, 3, 4, 1'b0, -1, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
